usbfs_tx_pkt: RTL and testbench
===============================

// Module: usbfs_tx_pkt
// PURPOSE
//  Downstream packetiser for USB full-speed IN endpoints: owns the packet buffer written via the endpoint's
//  etWr* interface, emits a byte stream PID, payload, CRC16 to the bit-level NRZI/bit-stuff serialiser.
//  Pulses o_etTxAccepted once the DATAx PID byte is taken, which starts the endpoint's buffer writes.
//  Also emits bare handshake packets (ACK/NAK/STALL). SYNC/EOP are added by the serialiser, not here.
// PARAMETERS
//  MAX_PKT  8  max payload bytes; power of 2, >=8
//  WR_LAT   2  cycles after PID accept before the first payload slot is evaluated (endpoint write latency)
// PORTS
//  i_clk           in   1        clock
//  i_rst_n         in   1        reset, asynchronous, active-low
//  i_txReq         in   1        start packet; sampled only when o_txBusy==0
//  i_txPid         in   4        PID: DATA0=4'h3 DATA1=4'hB ACK=4'h2 NAK=4'hA STALL=4'hE
//  o_txBusy        out  1        packet in progress (state!=IDLE)
//  o_etTxAccepted  out  1        1-cycle pulse: DATAx PID byte accepted by serialiser
//  i_etWrEn        in   1        buffer write strobe
//  i_etWrIdx       in   clog2(MAX_PKT)  buffer write index
//  i_etWrByte      in   8        buffer write data
//  o_txValid       out  1        byte valid to serialiser
//  o_txData        out  8        byte, serialiser sends LSB first
//  o_txLast        out  1        final byte of packet (qualifies o_txValid)
//  i_txReady       in   1        serialiser takes byte when o_txValid&&i_txReady
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE; o_txBusy, o_txValid, o_txLast, o_etTxAccepted=0; o_txData=0;
//   wrCnt=0, rdIdx=0, crc=16'hFFFF. Buffer contents not reset. Reset mid-packet aborts silently.
//  Outputs registered. Once o_txValid=1, o_txData/o_txLast hold until accepted (no retraction).
//  FSM: IDLE -> PID -> (handshake: IDLE) | (DATAx: DWAIT -> DATA -> CRC_LO -> CRC_HI -> IDLE).
//  IDLE: on i_txReq, load PID byte {~pid,pid}, o_txValid=1 next cycle; o_txLast=1 iff handshake PID.
//   wrCnt, rdIdx cleared and crc=16'hFFFF at the same edge. Unknown PID: treated as handshake.
//  PID: on accept, handshake -> IDLE; DATAx -> DWAIT, o_etTxAccepted=1 for exactly that next cycle.
//  DWAIT: counts WR_LAT cycles, o_txValid=0, then -> DATA.
//  DATA: each slot (o_txValid==0 or being accepted): if rdIdx<wrCnt && rdIdx<MAX_PKT present buf[rdIdx],
//   rdIdx++, crc updated with that byte at present time; else -> CRC_LO (payload ends on first empty slot).
//   Endpoint must sustain writes at least one byte per slot; underrun terminates packet (by design).
//  CRC: USB CRC16, poly 0x8005 reflected (0xA001), init 16'hFFFF, byte LSB first; sent value = ~crc.
//   CRC_LO presents ~crc[7:0], CRC_HI presents ~crc[15:8] with o_txLast=1; accept -> IDLE.
//   Zero-length DATAx: CRC bytes 8'h00, 8'h00.
//  Writes: i_etWrEn stores buf[i_etWrIdx]=i_etWrByte in any state; wrCnt++ saturating at MAX_PKT.
//   Indices must be sequential from 0 per packet. Write while IDLE and i_txReq same cycle: request's clear wins,
//   write stored but not counted.
//  Simultaneous accept+state change: next byte may be presented in the cycle after accept (back-to-back OK).
//  i_txReq while o_txBusy: ignored (assertion flags it). wrIdx wrap at MAX_PKT-1 -> 0 allowed.
//  Width: wrCnt/rdIdx are clog2(MAX_PKT)+1 bits to represent MAX_PKT.
// STRUCTURE
//  usbfs_pkg: PID localparams (DATA0/1, ACK, NAK, STALL), CRC16 poly/init/residual constants,
//   FSM state encoding.
//  Sub-module usbfs_crc16: combinational per-byte update (i_crc[15:0], i_byte[7:0] -> o_crc[15:0]).
//  Buffer: flop array MAX_PKT x 8 in this module; single read port indexed by rdIdx.
// TESTING
//  ACK: i_txReq, i_txPid=4'h2 -> single byte 8'hD2, o_txLast=1, o_etTxAccepted never pulses.
//  DATA0 empty, no writes -> bytes C3,00,00; last on 3rd; o_etTxAccepted 1 cycle after C3 accept.
//  DATA1, MAX_PKT=16, writes "123456789" after accept -> 4B,31..39,C8,B4 (CRC check 0xB4C8).
//  DATA0 MAX_PKT=8 with 8 writes plus extra write -> exactly 8 payload bytes, wrCnt saturates, CRC correct.
//  Random i_txReady backpressure on DATA1 4-byte payload -> byte stream identical, o_txData stable while stalled.
//  Assert i_rst_n=0 during CRC_LO -> all outputs 0 asynchronously; next i_txReq ACK sends D2 normally.

Source files
------------

// File: rtl/usbfs_pkg.sv
// USB full-speed transmit packetiser shared definitions.
// Holds the PID codes, the CRC16 constants and the packetiser FSM encoding.
// Has no logic and no latency.
package usbfs_pkg;

  // Token-independent PIDs this block can send
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // USB CRC16: poly 0x8005 processed LSB first, so the reflected form is used
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  // Remainder a receiver sees after clocking in a good packet including its CRC
  localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DWAIT,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } tx_state_e;

  // Only DATA0/DATA1 carry a payload; anything else goes out as a bare one-byte packet
  function automatic logic pid_is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usbfs_crc16.sv
// One-byte update of the USB CRC16 (reflected 0xA001, byte consumed LSB first).
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module usbfs_crc16
  import usbfs_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  // Eight serial LFSR steps unrolled, bit 0 of the byte first
  always_comb begin
    logic [15:0] c;
    c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ i_byte[i]) begin
        c = (c >> 1) ^ CRC16_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    o_crc = c;
  end

endmodule

// File: rtl/usbfs_tx_pkt.sv
// USB FS IN-endpoint packetiser: PID, payload from the local buffer, CRC16 (or a bare handshake).
// Latency: byte valid one cycle after request; payload starts WR_LAT cycles after the PID is taken.
// Backpressure: valid/ready; a presented byte and its last flag hold until i_txReady accepts it.
module usbfs_tx_pkt
  import usbfs_pkg::*;
#(
  parameter int MAX_PKT = 8,
  parameter int WR_LAT  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_txReq,
  input  logic [3:0]                 i_txPid,
  output logic                       o_txBusy,
  output logic                       o_etTxAccepted,
  input  logic                       i_etWrEn,
  input  logic [$clog2(MAX_PKT)-1:0] i_etWrIdx,
  input  logic [7:0]                 i_etWrByte,
  output logic                       o_txValid,
  output logic [7:0]                 o_txData,
  output logic                       o_txLast,
  input  logic                       i_txReady
);

  localparam int IW = $clog2(MAX_PKT);
  localparam int CW = IW + 1;
  localparam int LW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  tx_state_e       state_q, state_d;
  logic            vld_q, vld_d;
  logic [7:0]      dat_q, dat_d;
  logic            last_q, last_d;
  logic            acc_q, acc_d;
  logic            is_data_q, is_data_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]     crc_q, crc_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [7:0]      buf_q [MAX_PKT];

  logic            accept;
  logic            slot;
  logic            have_data;
  logic [7:0]      rd_byte;
  logic [15:0]     crc_nxt;

  assign accept    = vld_q & i_txReady;
  // A payload slot opens when nothing is pending or the pending byte leaves this cycle
  assign slot      = ~vld_q | i_txReady;
  assign have_data = (rd_idx_q < wr_cnt_q) && (rd_idx_q < MAX_CNT);
  assign rd_byte   = buf_q[rd_idx_q[IW-1:0]];

  usbfs_crc16 u_crc (
    .i_crc  (crc_q),
    .i_byte (rd_byte),
    .o_crc  (crc_nxt)
  );

  // Packet buffer: plain write port, contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (i_etWrEn) begin
      buf_q[i_etWrIdx] <= i_etWrByte;
    end
  end

  // Next-state and output-register logic for the packet FSM
  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    dat_d     = dat_q;
    last_d    = last_q;
    acc_d     = 1'b0;
    is_data_d = is_data_q;
    rd_idx_d  = rd_idx_q;
    crc_d     = crc_q;
    wait_d    = wait_q;
    wr_cnt_d  = wr_cnt_q;
    if (i_etWrEn && (wr_cnt_q != MAX_CNT)) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_txReq) begin
          state_d   = ST_PID;
          vld_d     = 1'b1;
          dat_d     = {~i_txPid, i_txPid};
          is_data_d = pid_is_data(i_txPid);
          last_d    = ~pid_is_data(i_txPid);
          // New packet starts from an empty buffer; a coincident write is dropped from the count
          wr_cnt_d  = '0;
          rd_idx_d  = '0;
          crc_d     = CRC16_INIT;
        end
      end
      ST_PID: begin
        if (accept) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (is_data_q) begin
            state_d = ST_DWAIT;
            acc_d   = 1'b1;
            wait_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DWAIT: begin
        if ((WR_LAT <= 1) || (wait_q == LW'(WR_LAT - 1))) begin
          state_d = ST_DATA;
        end else begin
          wait_d = wait_q + LW'(1);
        end
      end
      ST_DATA: begin
        if (slot) begin
          if (have_data) begin
            vld_d    = 1'b1;
            dat_d    = rd_byte;
            rd_idx_d = rd_idx_q + CW'(1);
            crc_d    = crc_nxt;
          end else begin
            // First empty slot ends the payload; CRC low byte follows without a gap
            state_d = ST_CRC_LO;
            vld_d   = 1'b1;
            dat_d   = ~crc_q[7:0];
          end
        end
      end
      ST_CRC_LO: begin
        if (accept) begin
          state_d = ST_CRC_HI;
          dat_d   = ~crc_q[15:8];
          last_d  = 1'b1;
        end
      end
      ST_CRC_HI: begin
        if (accept) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any packet in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      vld_q     <= 1'b0;
      dat_q     <= 8'h00;
      last_q    <= 1'b0;
      acc_q     <= 1'b0;
      is_data_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      crc_q     <= CRC16_INIT;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      is_data_q <= is_data_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      crc_q     <= crc_d;
      wait_q    <= wait_d;
    end
  end

  assign o_txBusy       = (state_q != ST_IDLE);
  assign o_etTxAccepted = acc_q;
  assign o_txValid      = vld_q;
  assign o_txData       = dat_q;
  assign o_txLast       = last_q;

  // A request while busy is silently dropped by the FSM; make it visible in simulation
  a_no_req_while_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_txReq && o_txBusy));

endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// Self-checking bench for usbfs_tx_pkt (MAX_PKT=16, WR_LAT=2).
// Expected {last,byte} words are queued per packet and popped by the byte monitor.
// The monitor also checks the accepted pulse timing and output hold under backpressure.
module tb_usbfs_tx_pkt;
  localparam int MAX_PKT = 16;
  localparam int WR_LAT  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [3:0] pid;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [7:0] wr_byte;
  logic       ready;
  logic       busy, acc, vld, last;
  logic [7:0] dat;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  usbfs_tx_pkt #(.MAX_PKT(MAX_PKT), .WR_LAT(WR_LAT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_txReq        (req),
    .i_txPid        (pid),
    .o_txBusy       (busy),
    .o_etTxAccepted (acc),
    .i_etWrEn       (wr_en),
    .i_etWrIdx      (wr_idx),
    .i_etWrByte     (wr_byte),
    .o_txValid      (vld),
    .o_txData       (dat),
    .o_txLast       (last),
    .i_txReady      (ready)
  );

  // Reference CRC16/USB, returned already inverted as it goes on the wire
  function automatic logic [15:0] usb_crc(input logic [7:0] m[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (m[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ m[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  function automatic void build_exp(input logic [3:0] p, input logic [7:0] pl[$], output logic [8:0] e[$]);
    logic [15:0] c;
    e.delete();
    e.push_back({1'b0, ~p, p});
    foreach (pl[k]) e.push_back({1'b0, pl[k]});
    c = usb_crc(pl);
    e.push_back({1'b0, c[7:0]});
    e.push_back({1'b1, c[15:8]});
  endfunction

  // Byte monitor: scoreboard pop, accepted-pulse timing, hold-while-stalled
  logic       acc_exp = 1'b0;
  logic       first = 1'b1;
  logic       pv = 1'b0, pacc = 1'b0, plast = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_exp = 1'b0;
      first   = 1'b1;
      pv      = 1'b0;
    end else begin
      checks++;
      if (acc !== acc_exp) begin
        errors++;
        $display("FAIL acc_pulse t=%0t: got %b want %b", $time, acc, acc_exp);
      end
      if (pv && !pacc) begin
        checks++;
        if (vld !== 1'b1 || dat !== pd || last !== plast) begin
          errors++;
          $display("FAIL hold t=%0t: got v=%b d=%h l=%b want v=1 d=%h l=%b", $time, vld, dat, last, pd, plast);
        end
      end
      acc_exp = 1'b0;
      if (vld && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte t=%0t: got unexpected %b_%h want none", $time, last, dat);
        end else begin
          e = exp_q.pop_front();
          if ({last, dat} !== e) begin
            errors++;
            $display("FAIL byte t=%0t: got %b_%h want %b_%h", $time, last, dat, e[8], e[7:0]);
          end
          acc_exp = first && (e[7:0] == 8'hC3 || e[7:0] == 8'h4B);
          first   = e[8];
        end
      end
      pv    = vld;
      pacc  = vld && ready;
      pd    = dat;
      plast = last;
    end
  end

  task automatic wait_idle();
    for (int c = 0; c < 100 && busy; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_pkt(input string name, input logic [3:0] p, input logic [7:0] wr[$],
                         input logic [8:0] ex[$], input bit rnd, input bit wr_at_req);
    int wi;
    bit started, done;
    foreach (ex[k]) exp_q.push_back(ex[k]);
    wait_idle();
    req   = 1'b1;
    pid   = p;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wr_at_req) begin
      wr_en = 1'b1; wr_idx = 4'd0; wr_byte = 8'hAA;
    end
    @(posedge clk); #1;
    req   = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b want 1", name, busy);
    end
    wi = 0; started = 0; done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (acc) started = 1;
      if (started && wi < wr.size()) begin
        wr_en = 1'b1; wr_idx = 4'(wi % MAX_PKT); wr_byte = wr[wi]; wi++;
      end else begin
        wr_en = 1'b0;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      done = !busy && exp_q.size() == 0 && wi == wr.size();
    end
    wr_en = 1'b0;
    ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d want idle and 0", name, busy, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (vld !== 1'b0 || last !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_out: got v=%b l=%b want 0 0", name, vld, last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; pid = 4'h0; wr_en = 1'b0; wr_idx = 4'd0; wr_byte = 8'h00; ready = 1'b1;
    #12;
    checks++;
    if ({busy, vld, last, acc, dat} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outs: got b=%b v=%b l=%b a=%b d=%h want all 0", busy, vld, last, acc, dat);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, vld} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got b=%b v=%b want 0 0", busy, vld);
    end
  endtask

  task automatic test_handshakes();
    logic [7:0] none[$];
    logic [8:0] ex[$];
    logic [3:0] pids[4];
    logic [7:0] bytes[4];
    pids  = '{4'h2, 4'hA, 4'hE, 4'h1};
    bytes = '{8'hD2, 8'h5A, 8'h1E, 8'hE1};
    for (int i = 0; i < 4; i++) begin
      ex.delete();
      ex.push_back({1'b1, bytes[i]});
      run_pkt("handshake", pids[i], none, ex, 1'b0, 1'b0);
    end
  endtask

  task automatic test_data0_empty();
    logic [7:0] none[$];
    logic [8:0] ex[$];
    ex = '{9'h0C3, 9'h000, 9'h100};
    run_pkt("data0_empty", 4'h3, none, ex, 1'b0, 1'b1);
  endtask

  task automatic test_crc_check();
    logic [7:0] wr[$];
    logic [8:0] ex[$];
    ex.push_back(9'h04B);
    for (int i = 0; i < 9; i++) begin
      wr.push_back(8'h31 + 8'(i));
      ex.push_back({1'b0, 8'h31 + 8'(i)});
    end
    ex.push_back(9'h0C8);
    ex.push_back(9'h1B4);
    run_pkt("crc_check", 4'hB, wr, ex, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    logic [7:0] wr[$];
    logic [7:0] pl[$];
    logic [8:0] ex[$];
    for (int i = 0; i < MAX_PKT; i++) begin
      wr.push_back(8'h10 + 8'(i * 7));
      pl.push_back(8'h10 + 8'(i * 7));
    end
    wr.push_back(8'hEE);
    build_exp(4'h3, pl, ex);
    run_pkt("saturate", 4'h3, wr, ex, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] pl[$];
    logic [8:0] ex[$];
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_exp(4'hB, pl, ex);
    for (int r = 0; r < 3; r++) run_pkt("backpressure", 4'hB, pl, ex, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] none[$];
    logic [8:0] ex[$];
    bit seen;
    exp_q.push_back(9'h0C3);
    wait_idle();
    req = 1'b1; pid = 4'h3; ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (acc) ready = 1'b0;
      @(posedge clk); #1;
      seen = vld && !ready;
    end
    checks++;
    if (!seen || dat !== 8'h00 || last !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL crc_lo_reach: got seen=%b d=%h l=%b b=%b want 1 00 0 1", seen, dat, last, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, vld, last, acc, dat} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got b=%b v=%b l=%b a=%b d=%h want all 0", busy, vld, last, acc, dat);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    ready = 1'b1;
    @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    ex = '{9'h1D2};
    run_pkt("ack_after_reset", 4'h2, none, ex, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_handshakes();
    test_data0_empty();
    test_crc_check();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
